// File: rtl/uart_rx_if.sv
// Receive-side bundle for uart_rx: serial input plus byte/status outputs.
interface uart_rx_if;
  logic       rx_pin;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  modport master (output rx_pin, input  data_out, data_valid, frame_err, busy);
  modport slave  (input  rx_pin, output data_out, data_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle
// data_valid / frame_err pulses, break hold-off until the line returns high.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.slave  rx
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] data_q;
  logic                 dv_q, fe_q, busy_q;
  logic                 rx_meta, rx_s;

  // Both stages reset high so a line held low through reset still looks like a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx.rx_pin;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      fe_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) begin
            state  <= START;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + IW'(1);
            if (bit_idx == LAST_BIT) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              data_q <= shreg;
              dv_q   <= 1'b1;
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              fe_q  <= 1'b1;
              state <= BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx.data_out   = data_q;
  assign rx.data_valid = dv_q;
  assign rx.frame_err  = fe_q;
  assign rx.busy       = busy_q;
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per UART bit period; legal range 4..65535.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; fixed at 8 for this revision.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rx_pin  input  1  serial line, asynchronous to clk, idle high, 8N1, LSB first.
REQ-006 data_out  output  8  last correctly received byte.
REQ-007 data_valid  output  1  one-cycle pulse, data_out newly updated.
REQ-008 frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE; suitable for a LED.

Function
REQ-010 rx_pin SHALL pass through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value rx_s.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-012 IDLE: rx_s==0 SHALL move to START with the bit counter cleared.
REQ-013 START: after CLKS_PER_BIT/2 cycles (integer division), sample rx_s; 0 -> DATA with counter cleared; 1 -> IDLE as a glitch, no output pulse.
REQ-014 DATA: every CLKS_PER_BIT cycles, sample rx_s into bit index 0..7, LSB first; after bit 7 -> STOP.
REQ-015 STOP: after CLKS_PER_BIT cycles, sample rx_s; 1 -> load data_out, pulse data_valid, go to IDLE; 0 -> pulse frame_err, keep data_out unchanged, go to BREAK.
REQ-016 BREAK: remain until rx_s==1, then go to IDLE; no pulses while in BREAK.
REQ-017 data_valid and frame_err SHALL be asserted on the clk edge following the stop-bit sample and SHALL last exactly one cycle; they SHALL never be high together.
REQ-018 Latency: a start-bit falling edge on rx_pin SHALL produce data_valid 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles later, +/-1 cycle for pin phase.
REQ-019 The baud counter SHALL be $clog2(CLKS_PER_BIT)+1 bits wide, SHALL restart at 0 on every state change, and SHALL never wrap inside a bit period.
REQ-020 A new start bit arriving immediately after the stop sample (back-to-back frames) SHALL be detected from IDLE with no lost frame.
REQ-021 data_out SHALL hold its value until the next valid frame; it SHALL not change on a glitch, a framing error or BREAK.
REQ-022 The shift register SHALL be internal; partially received bits SHALL never appear on data_out.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, counters 0, shift register 0, data_out 8'h00, data_valid 0, frame_err 0, busy 0, and synchronizer flops 1.
REQ-024 Reset asserted mid-frame SHALL discard the frame; after release, the receiver SHALL wait for a fresh falling edge, and a line already low at release SHALL be treated as a start edge.
REQ-025 Reset release SHALL be synchronous to clk in effect: no state change on the release edge itself.

Verification (CLKS_PER_BIT=16)
REQ-026 Send 0x9A as 8N1 at 16 clk/bit -> exactly one data_valid pulse, data_out=0x9A, frame_err never high, busy high for the frame duration.
REQ-027 Drive rx_pin low for 4 cycles then high -> busy high for at most 8+2 cycles, no data_valid or frame_err, data_out unchanged.
REQ-028 Send 0x55 with stop bit 0, hold low 40 cycles, then release -> one frame_err pulse, data_out keeps previous value, busy stays high until rx high, then returns to IDLE.
REQ-029 Send 0x00 then 0xFF back-to-back with no idle gap -> two data_valid pulses 160 cycles apart, values 0x00 then 0xFF.
REQ-030 Assert rst_n low during data bit 3 of 0xA5, release, then send 0x3C -> no pulse for 0xA5, data_out=0x00 after reset, then 0x3C with one data_valid.
REQ-031 Bench SHALL loop frames of all 256 byte values against a behavioural transmitter model and compare every received byte.
